// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_MARGIN = 2;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy counter width; wide enough to hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read by address.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with threshold flags, overflow/underflow
// pulses and selectable registered or first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int DEPTH             = DEF_DEPTH,
  parameter int NEAR_FULL_MARGIN  = DEF_MARGIN,
  parameter int NEAR_EMPTY_MARGIN = DEF_MARGIN,
  parameter int FWFT              = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      near_full,
  output logic                      empty,
  output logic                      near_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam bit IS_FWFT = (FWFT == int'(sync_fifo_pkg::FWFT));

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] NF_TH    = CW'(DEPTH - NEAR_FULL_MARGIN);
  localparam logic [CW-1:0] NE_TH    = CW'(NEAR_EMPTY_MARGIN);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] rdata;

  assign full       = (count == FULL_CNT);
  assign near_full  = (count >= NF_TH);
  assign empty      = (count == '0);
  assign near_empty = (count <= NE_TH);

  // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc & ~rst),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & ~rd_acc;
    end
  end

  generate
    if (IS_FWFT) begin : g_fwft
      assign data_out = rdata;
      assign valid    = ~empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
          valid    <= 1'b0;
        end else if (rd_acc) begin
          data_out <= rdata;
          valid    <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a queue model scores the standard-read
// instance every cycle; a second FWFT instance gets directed checks.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // standard-read instance
  logic         wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0] data_in = '0, data_out;
  logic         valid, full, near_full, empty, near_empty, overflow, underflow;
  logic [CW-1:0] count;

  // FWFT instance
  logic         wr2 = 1'b0, rd2 = 1'b0;
  logic [W-1:0] din2 = '0, dout2;
  logic         valid2, full2, nfull2, empty2, nempty2, ovf2, unf2;
  logic [CW-1:0] count2;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .NEAR_FULL_MARGIN(2),
                    .NEAR_EMPTY_MARGIN(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid(valid), .count(count), .full(full),
    .near_full(near_full), .empty(empty), .near_empty(near_empty),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .NEAR_FULL_MARGIN(2),
                    .NEAR_EMPTY_MARGIN(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr2), .data_in(din2), .rd_en(rd2),
    .data_out(dout2), .valid(valid2), .count(count2), .full(full2),
    .near_full(nfull2), .empty(empty2), .near_empty(nempty2),
    .overflow(ovf2), .underflow(unf2));

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard / reference state
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_dout = '0;
  logic         exp_valid = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".count"},      32'(count),      32'(n));
    chk({tag, ".full"},       32'(full),       32'(n == D));
    chk({tag, ".near_full"},  32'(near_full),  32'(n >= D - 2));
    chk({tag, ".empty"},      32'(empty),      32'(n == 0));
    chk({tag, ".near_empty"}, 32'(near_empty), 32'(n <= 2));
    chk({tag, ".overflow"},   32'(overflow),   32'(exp_ovf));
    chk({tag, ".underflow"},  32'(underflow),  32'(exp_unf));
    chk({tag, ".valid"},      32'(valid),      32'(exp_valid));
    chk({tag, ".data_out"},   32'(data_out),   32'(exp_dout));
  endtask

  // One clock on the standard instance with the reference model stepped alongside.
  task automatic cyc(input string tag, input logic w, input logic [W-1:0] d, input logic r);
    logic ra, wa;
    ra = r && (sb.size() > 0);
    wa = w && ((sb.size() < D) || ra);
    exp_ovf = w && !wa;
    exp_unf = r && !ra;
    exp_valid = ra;
    if (ra) exp_dout = sb.pop_front();
    if (wa) sb.push_back(d);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic w);
    rst = 1'b1; wr_en = w; data_in = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    sb.delete();
    exp_dout = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat[5];
    pat[0] = 8'h41; pat[1] = 8'h22; pat[2] = 8'h7D; pat[3] = 8'hFF; pat[4] = 8'h3A;

    // 1: fill to full, then one rejected write
    do_reset("t1.rst", 1'b0);
    chk("t1.fwft_rst.valid", 32'(valid2), 32'd0);
    chk("t1.fwft_rst.empty", 32'(empty2), 32'd1);
    for (int i = 0; i < D; i++) cyc("t1.wr", 1'b1, W'(i), 1'b0);
    cyc("t1.ovf", 1'b1, 8'h20, 1'b0);
    cyc("t1.ovf_clr", 1'b0, 8'h00, 1'b0);

    // 2: drain with one extra read
    for (int i = 0; i < D + 1; i++) cyc("t2.rd", 1'b0, 8'h00, 1'b1);
    cyc("t2.idle", 1'b0, 8'h00, 1'b0);

    // 3: pattern then simultaneous read/write, repeated to wrap pointers
    do_reset("t3.rst", 1'b0);
    for (int i = 0; i < 5; i++) cyc("t3.wr", 1'b1, pat[i], 1'b0);
    cyc("t3.rw", 1'b1, 8'h99, 1'b1);
    cyc("t3.rw", 1'b1, 8'h86, 1'b1);
    cyc("t3.rw", 1'b1, 8'hBC, 1'b1);
    for (int i = 0; i < 40; i++) cyc("t3.wrap", 1'b1, W'($urandom), 1'b1);

    // 4: full with simultaneous read/write
    while (sb.size() < D) cyc("t4.fill", 1'b1, W'($urandom), 1'b0);
    cyc("t4.rw_full", 1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < D; i++) cyc("t4.rd", 1'b0, 8'h00, 1'b1);
    chk("t4.last_5a", 32'(data_out), 32'h5A);

    // 5: reset mid-operation overrides wr_en
    for (int i = 0; i < 17; i++) cyc("t5.wr", 1'b1, W'(8'hC0 + i), 1'b0);
    do_reset("t5.rst", 1'b1);
    cyc("t5.wr33", 1'b1, 8'h33, 1'b0);
    cyc("t5.rd33", 1'b0, 8'h00, 1'b1);
    chk("t5.dout33", 32'(data_out), 32'h33);

    // 6: FWFT instance
    wr2 = 1'b1; din2 = 8'hA5;
    @(posedge clk); #1; wr2 = 1'b0;
    chk("t6.valid", 32'(valid2), 32'd1);
    chk("t6.dout",  32'(dout2),  32'hA5);
    chk("t6.count", 32'(count2), 32'd1);
    rd2 = 1'b1;
    @(posedge clk); #1; rd2 = 1'b0;
    chk("t6.pop.valid", 32'(valid2), 32'd0);
    chk("t6.pop.empty", 32'(empty2), 32'd1);
    chk("t6.pop.unf",   32'(unf2),   32'd0);
    rd2 = 1'b1;
    @(posedge clk); #1; rd2 = 1'b0;
    chk("t6.unf", 32'(unf2), 32'd1);
    wr2 = 1'b1; din2 = 8'h11;
    @(posedge clk); #1; din2 = 8'h3C;
    @(posedge clk); #1; wr2 = 1'b0;
    chk("t6.head", 32'(dout2), 32'h11);
    chk("t6.unf_clr", 32'(unf2), 32'd0);
    rd2 = 1'b1;
    @(posedge clk); #1; rd2 = 1'b0;
    chk("t6.next", 32'(dout2), 32'h3C);
    chk("t6.next.valid", 32'(valid2), 32'd1);
    chk("t6.next.count", 32'(count2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parameterised synchronous FIFO. It is the successor to the fixed 8x32 FIFO and generalises width, depth, flag thresholds and read mode. It fixes the count width so that a full FIFO is representable, and it allows a write into a full FIFO when a read happens in the same cycle. It sits between any single-clock producer/consumer pair in the datapath and is the standard buffer for new blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=4
NEAR_FULL_MARGIN, 2, near_full asserts when count >= DEPTH-NEAR_FULL_MARGIN
NEAR_EMPTY_MARGIN, 2, near_empty asserts when count <= NEAR_EMPTY_MARGIN
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
data_in  in  WIDTH  write data
rd_en  in  1  read request (FWFT=1: pop/acknowledge)
data_out  out  WIDTH  read data
valid  out  1  data_out carries a freshly read word (FWFT=1: head word present)
count  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH
full  out  1  count==DEPTH
near_full  out  1  count >= DEPTH-NEAR_FULL_MARGIN
empty  out  1  count==0
near_empty  out  1  count <= NEAR_EMPTY_MARGIN
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (one clk edge with rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid=0, overflow=0, underflow=0.
  - Flags: empty=1, near_empty=1, full=0, near_full=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words; rst overrides wr_en/rd_en in that cycle.
- Accept logic:
  - rd_acc = rd_en & ~empty
  - wr_acc = wr_en & (~full | rd_acc)
- Pointers: $clog2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0.
  - wr_acc: mem[wr_ptr] <= data_in, wr_ptr++.
  - rd_acc: rd_ptr++.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Flags: combinational decode of registered count, so they change in the same cycle count changes.
- overflow: registered; =1 for the cycle after a cycle with wr_en & ~wr_acc, else 0. Rejected data is dropped.
- underflow: registered; =1 for the cycle after a cycle with rd_en & ~rd_acc, else 0.
- FWFT=0 (standard read):
  - On rd_acc, data_out <= mem[rd_ptr] and valid <= 1, giving 1-cycle read latency.
  - Otherwise valid <= 0 and data_out holds its last value.
  - Write-to-read latency: a word written at edge N is readable by a rd_en sampled at edge N+1.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally; valid = ~empty.
  - rd_en pops the head word; the next word (if any) appears immediately after the popping edge.
  - A word written into an empty FIFO at edge N shows valid=1 after edge N.
- Simultaneous read and write:
  - When empty: only the write is accepted, and underflow pulses.
  - When full: both are accepted, with no overflow.

Decomposition:
- sync_fifo_pkg holds:
  - default constants (DEF_WIDTH=8, DEF_DEPTH=32, DEF_MARGIN=2);
  - function cnt_w(depth) returning $clog2(depth+1);
  - enum fifo_mode_e {STD, FWFT}, with the FWFT parameter compared against it.
- Sub-module fifo_mem: simple dual-port RAM, WIDTH x DEPTH, with synchronous write and asynchronous read by address. It is instantiated once.
- Pointers, count, flags and output registers stay in sync_fifo_param.

Test Plan:
1. WIDTH=8, DEPTH=32, FWFT=0: reset, then write 0x00..0x1F on consecutive cycles.
   -> near_full=1 at count=30; full=1 and count=32 after the 32nd write.
   -> A 33rd write (0x20) gives overflow=1 for one cycle; count stays 32.
2. From the full state, hold rd_en for 33 cycles.
   -> data_out=0x00..0x1F in order, with valid=1 the cycle after each accepted read.
   -> The 33rd read gives underflow=1, valid=0, data_out still 0x1F, empty=1, count=0.
3. After reset, write 0x41,0x22,0x7D,0xFF,0x3A, then assert rd_en and wr_en together while writing 0x99,0x86,0xBC.
   -> count stays 5.
   -> data_out sequence is 0x41,0x22,0x7D.
   -> Pointers wrap correctly when the test is repeated past 32 total writes.
4. Full FIFO (count=32), wr_en=rd_en=1 with data_in=0x5A.
   -> No overflow; count=32; the oldest word is output; 0x5A is read out 32 reads later.
5. count=17, pulse rst for one cycle with wr_en=1.
   -> The next cycle has count=0, empty=1, valid=0, overflow=underflow=0.
   -> Writing 0x33 and then reading returns 0x33.
6. FWFT=1 instance: write 0xA5 into an empty FIFO with rd_en=0.
   -> valid=1 and data_out=0xA5 the next cycle.
   -> Pulse rd_en: valid=0, empty=1.
   -> Pulse rd_en again: underflow=1.
